// File: rtl/xgri_pkg.sv
// xgri_pkg: register map offsets and status field positions shared by xgri_gen3
package xgri_pkg;
    localparam logic [5:0] REG_STATUS   = 6'h00;
    localparam logic [5:0] REG_IRQ_PEND = 6'h01;
    localparam logic [5:0] REG_IRQ_EN   = 6'h02;
    localparam logic [5:0] REG_H_SCROLL = 6'h03;
    localparam logic [5:0] REG_V_SCROLL = 6'h04;
    localparam logic [5:0] REG_CH_BASE  = 6'h10;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    typedef enum logic [1:0] {
        CH_ADDR  = 2'd0,
        CH_DATA  = 2'd1,
        CH_THR   = 2'd2,
        CH_LEVEL = 2'd3
    } ch_reg_e;
    function automatic int stat_lsb(input int field, input int num_ch);
        return field * num_ch;
    endfunction
endpackage

// File: rtl/xgri_fifo.sv
// xgri_fifo: single-clock FIFO with combinational head word and occupancy output
module xgri_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_sys,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = wp - rp;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = wp == rp;
    assign rdata   = mem[rp[AW-1:0]];
    always_ff @(posedge clk_sys or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wp + (AW+1)'(do_push);
            rp <= rp + (AW+1)'(do_pop);
        end
    // storage is not reset; pointers alone define validity
    always_ff @(posedge clk_sys)
        if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/xgri_gen3.sv
// xgri_gen3: CPU register block feeding NUM_CH write FIFOs with burst-stepped channel addresses
module xgri_gen3
    import xgri_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 16,
    parameter int BURST  = 4,
    parameter int STEP   = 1
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic                      ri_en,
    input  logic                      ri_wren,
    input  logic                      ri_ren,
    input  logic [5:0]                ri_addr,
    input  logic [DATA_W-1:0]         from_cpu,
    output logic [DATA_W-1:0]         to_cpu,
    output logic [10:0]               ri_h_scroll,
    output logic [9:0]                ri_v_scroll,
    output logic                      irq,
    input  logic [NUM_CH-1:0]         ch_pop,
    output logic [NUM_CH-1:0]         ch_full,
    output logic [NUM_CH-1:0]         ch_empty,
    output logic [NUM_CH*DATA_W-1:0]  ch_data,
    output logic [NUM_CH*ADDR_W-1:0]  ch_addr
);
    localparam int TW = $clog2(DEPTH) + 1;
    localparam int BW = BURST > 1 ? $clog2(BURST) : 1;
    logic wr, rd, ch_sel;
    logic [1:0] ch_idx;
    ch_reg_e ch_off;
    logic [NUM_CH-1:0] push, pend_set, ovf, pend, en, ovf_clr, pend_clr;
    logic [NUM_CH*TW-1:0] thr_f, lvl_f;
    logic [3*NUM_CH-1:0] stat;
    logic [DATA_W-1:0] rdata;
    assign wr     = ri_en & ri_wren;
    assign rd     = ri_en & ri_ren;
    assign ch_idx = ri_addr[3:2];
    assign ch_off = ch_reg_e'(ri_addr[1:0]);
    assign ch_sel = ri_addr[5:4] == REG_CH_BASE[5:4] && int'(ch_idx) < NUM_CH;
    assign stat[stat_lsb(ST_EMPTY, NUM_CH) +: NUM_CH] = ch_empty;
    assign stat[stat_lsb(ST_FULL, NUM_CH) +: NUM_CH]  = ch_full;
    assign stat[stat_lsb(ST_OVF, NUM_CH) +: NUM_CH]   = ovf;
    assign ovf_clr  = wr && ri_addr == REG_STATUS ? from_cpu[stat_lsb(ST_OVF, NUM_CH) +: NUM_CH] : '0;
    assign pend_clr = wr && ri_addr == REG_IRQ_PEND ? from_cpu[NUM_CH-1:0] : '0;
    genvar c;
    for (c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit, pop_ok, push_ok, wrap;
        logic [TW-1:0] lvl, lvl_nxt, t_q;
        logic [ADDR_W-1:0] a_q;
        logic [BW-1:0] b_q;
        assign hit     = wr && ch_sel && ch_idx == 2'(c);
        assign push[c] = hit && ch_off == CH_DATA;
        assign push_ok = push[c] & ~ch_full[c];
        assign pop_ok  = ch_pop[c] & ~ch_empty[c];
        assign lvl_nxt = lvl + TW'(push_ok) - TW'(pop_ok);
        // low-water crossing is judged on this edge's level change
        assign pend_set[c] = lvl > t_q && lvl_nxt <= t_q;
        assign wrap    = b_q == BW'(BURST - 1);
        assign thr_f[c*TW +: TW] = t_q;
        assign lvl_f[c*TW +: TW] = lvl;
        assign ch_addr[c*ADDR_W +: ADDR_W] = a_q;
        xgri_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk_sys(clk_sys),
            .rst(rst),
            .push(push[c]),
            .pop(ch_pop[c]),
            .wdata(from_cpu),
            .rdata(ch_data[c*DATA_W +: DATA_W]),
            .full(ch_full[c]),
            .empty(ch_empty[c]),
            .level(lvl)
        );
        always_ff @(posedge clk_sys or posedge rst)
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
                t_q <= '0;
            end else begin
                if (hit && ch_off == CH_ADDR) begin
                    a_q <= from_cpu[ADDR_W-1:0];
                    b_q <= '0;
                end else if (pop_ok) begin
                    b_q <= wrap ? '0 : b_q + BW'(1);
                    if (wrap) a_q <= a_q + ADDR_W'(STEP);
                end
                if (hit && ch_off == CH_THR) t_q <= from_cpu[TW-1:0];
            end
    end
    assign rdata = ch_sel ? (ch_off == CH_ADDR  ? DATA_W'(ch_addr[ch_idx*ADDR_W +: ADDR_W]) :
                             ch_off == CH_THR   ? DATA_W'(thr_f[ch_idx*TW +: TW]) :
                             ch_off == CH_LEVEL ? DATA_W'(lvl_f[ch_idx*TW +: TW]) : '0) :
                   ri_addr == REG_STATUS   ? DATA_W'(stat) :
                   ri_addr == REG_IRQ_PEND ? DATA_W'(pend) :
                   ri_addr == REG_IRQ_EN   ? DATA_W'(en) :
                   ri_addr == REG_H_SCROLL ? DATA_W'(ri_h_scroll) :
                   ri_addr == REG_V_SCROLL ? DATA_W'(ri_v_scroll) : '0;
    always_ff @(posedge clk_sys or posedge rst)
        if (rst) begin
            ovf         <= '0;
            pend        <= '0;
            en          <= '0;
            ri_h_scroll <= '0;
            ri_v_scroll <= '0;
            irq         <= '0;
            to_cpu      <= '0;
        end else begin
            ovf  <= (ovf & ~ovf_clr) | (push & ch_full);
            pend <= (pend & ~pend_clr) | pend_set;
            if (wr && ri_addr == REG_IRQ_EN) en <= from_cpu[NUM_CH-1:0];
            if (wr && ri_addr == REG_H_SCROLL) ri_h_scroll <= from_cpu[10:0];
            if (wr && ri_addr == REG_V_SCROLL) ri_v_scroll <= from_cpu[9:0];
            irq <= |(pend & en);
            if (rd) to_cpu <= rdata;
        end
endmodule

// File: tb/tb_xgri_gen3.sv
// tb_xgri_gen3: queue-based reference model with per-cycle compare plus directed literal checks
module tb_xgri_gen3;
    localparam int NCH = 2, DW = 16, AW = 15, DEPTH = 16, BURST = 4, STEP = 1;
    logic clk_sys = 0, rst = 0, ri_en, ri_wren, ri_ren;
    logic [5:0] ri_addr;
    logic [DW-1:0] from_cpu, to_cpu;
    logic [10:0] ri_h_scroll;
    logic [9:0] ri_v_scroll;
    logic irq;
    logic [NCH-1:0] ch_pop, ch_full, ch_empty;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH*AW-1:0] ch_addr;
    int checks = 0, errors = 0;
    bit chk_on = 0;
    logic [15:0] mq [NCH][$];
    int m_addr [NCH], m_bcnt [NCH], m_thr [NCH];
    logic [NCH-1:0] m_ovf = 0, m_pend = 0, m_en = 0;
    int m_h = 0, m_v = 0, m_to = 0;
    logic m_irq = 0;

    xgri_gen3 #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BURST(BURST), .STEP(STEP)) dut (
        .clk_sys(clk_sys), .rst(rst), .ri_en(ri_en), .ri_wren(ri_wren), .ri_ren(ri_ren),
        .ri_addr(ri_addr), .from_cpu(from_cpu), .to_cpu(to_cpu), .ri_h_scroll(ri_h_scroll),
        .ri_v_scroll(ri_v_scroll), .irq(irq), .ch_pop(ch_pop), .ch_full(ch_full),
        .ch_empty(ch_empty), .ch_data(ch_data), .ch_addr(ch_addr)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_read(input int a);
        int s = 0, c;
        if (a == 0) begin
            for (int k = 0; k < NCH; k++) begin
                s |= int'(mq[k].size() == 0) << k;
                s |= int'(mq[k].size() == DEPTH) << (NCH + k);
                s |= int'(m_ovf[k]) << (2*NCH + k);
            end
            return s;
        end
        if (a == 1) return int'(m_pend);
        if (a == 2) return int'(m_en);
        if (a == 3) return m_h;
        if (a == 4) return m_v;
        if (a < 16 || a >= 16 + 4*NCH) return 0;
        c = (a - 16) / 4;
        case (a % 4)
            0: return m_addr[c];
            2: return m_thr[c];
            3: return mq[c].size();
            default: return 0;
        endcase
    endfunction

    always @(posedge clk_sys or posedge rst) begin
        logic wr, rd;
        logic [NCH-1:0] pset, oset;
        int a, olvl, nlvl;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                m_addr[c] = 0; m_bcnt[c] = 0; m_thr[c] = 0;
            end
            m_ovf = 0; m_pend = 0; m_en = 0; m_h = 0; m_v = 0; m_to = 0; m_irq = 0;
        end else begin
            wr = ri_en & ri_wren;
            rd = ri_en & ri_ren;
            a = int'(ri_addr);
            pset = 0; oset = 0;
            m_irq = |(m_pend & m_en);
            if (rd) m_to = m_read(a);
            for (int c = 0; c < NCH; c++) begin
                olvl = mq[c].size();
                if (ch_pop[c] && olvl > 0) begin
                    void'(mq[c].pop_front());
                    m_bcnt[c]++;
                    if (m_bcnt[c] == BURST) begin
                        m_bcnt[c] = 0;
                        m_addr[c] = (m_addr[c] + STEP) % (1 << AW);
                    end
                end
                if (wr && a == 16 + 4*c + 1) begin
                    if (olvl < DEPTH) mq[c].push_back(from_cpu);
                    else oset[c] = 1;
                end
                nlvl = mq[c].size();
                if (olvl > m_thr[c] && nlvl <= m_thr[c]) pset[c] = 1;
                if (wr && a == 16 + 4*c) begin
                    m_addr[c] = int'(from_cpu) % (1 << AW);
                    m_bcnt[c] = 0;
                end
                if (wr && a == 16 + 4*c + 2) m_thr[c] = int'(from_cpu) & 31;
            end
            if (wr && a == 0) m_ovf &= ~from_cpu[2*NCH +: NCH];
            m_ovf |= oset;
            if (wr && a == 1) m_pend &= ~from_cpu[NCH-1:0];
            m_pend |= pset;
            if (wr && a == 2) m_en = from_cpu[NCH-1:0];
            if (wr && a == 3) m_h = int'(from_cpu) & 'h7FF;
            if (wr && a == 4) m_v = int'(from_cpu) & 'h3FF;
        end
    end

    always @(negedge clk_sys) if (chk_on) begin
        chk("to_cpu", to_cpu, m_to);
        chk("irq", irq, m_irq);
        chk("h_scroll", ri_h_scroll, m_h);
        chk("v_scroll", ri_v_scroll, m_v);
        for (int c = 0; c < NCH; c++) begin
            chk("ch_full", ch_full[c], mq[c].size() == DEPTH);
            chk("ch_empty", ch_empty[c], mq[c].size() == 0);
            chk("ch_addr", ch_addr[c*AW +: AW], m_addr[c]);
            if (mq[c].size() > 0) chk("ch_data", ch_data[c*DW +: DW], mq[c][0]);
        end
    end

    task automatic tick(); @(posedge clk_sys); #1; endtask
    task automatic idle();
        ri_en = 0; ri_wren = 0; ri_ren = 0; ri_addr = 0; from_cpu = 0; ch_pop = 0;
    endtask
    task automatic wr_reg(input logic [5:0] a, input logic [15:0] d);
        ri_en = 1; ri_wren = 1; ri_addr = a; from_cpu = d; tick(); idle();
    endtask
    task automatic rd_reg(input logic [5:0] a);
        ri_en = 1; ri_ren = 1; ri_addr = a; tick(); idle();
    endtask
    task automatic pop(input logic [NCH-1:0] m); ch_pop = m; tick(); idle(); endtask

    initial begin
        int r;
        idle();
        rst = 1;
        repeat (2) tick();
        chk_on = 1;
        @(negedge clk_sys);
        chk("rst_empty", ch_empty, 2'b11);
        chk("rst_full", ch_full, 0);
        chk("rst_addr", ch_addr, 0);
        chk("rst_to_cpu", to_cpu, 0);
        rst = 0;
        // single word round trip
        wr_reg(6'h11, 16'hA5A5);
        rd_reg(6'h13);
        @(negedge clk_sys);
        chk("level_one", to_cpu, 1);
        chk("head_a5a5", ch_data[15:0], 16'hA5A5);
        pop(2'b01);
        @(negedge clk_sys);
        chk("empty_after_pop", ch_empty[0], 1);
        // burst stepping
        wr_reg(6'h10, 16'h0010);
        for (int i = 0; i < 8; i++) begin
            wr_reg(6'h11, 16'(i));
            pop(2'b01);
            @(negedge clk_sys);
            if (i == 3) chk("addr_burst1", ch_addr[14:0], 15'h0011);
            if (i == 7) chk("addr_burst2", ch_addr[14:0], 15'h0012);
        end
        // overflow on ch1
        for (int i = 0; i < 17; i++) wr_reg(6'h15, 16'(16'h100 + i));
        @(negedge clk_sys);
        chk("ch1_full", ch_full[1], 1);
        chk("ch1_head", ch_data[31:16], 16'h0100);
        rd_reg(6'h17);
        @(negedge clk_sys);
        chk("ch1_level16", to_cpu, 16);
        rd_reg(6'h00);
        @(negedge clk_sys);
        chk("status_ovf", to_cpu, 16'h0029);
        wr_reg(6'h00, 16'h0020);
        rd_reg(6'h00);
        @(negedge clk_sys);
        chk("status_ovf_clr", to_cpu, 16'h0009);
        repeat (16) pop(2'b10);
        // low-water interrupt
        wr_reg(6'h12, 16'd2);
        wr_reg(6'h01, 16'h3);
        wr_reg(6'h02, 16'h1);
        for (int i = 0; i < 4; i++) wr_reg(6'h11, 16'(16'h200 + i));
        pop(2'b01);
        pop(2'b01);
        rd_reg(6'h01);
        @(negedge clk_sys);
        chk("pend0", to_cpu, 1);
        chk("irq_set", irq, 1);
        wr_reg(6'h01, 16'h1);
        tick();
        @(negedge clk_sys);
        chk("irq_clr", irq, 0);
        repeat (2) pop(2'b01);
        // address wrap and write-over-increment
        wr_reg(6'h10, 16'h7FFF);
        for (int i = 0; i < 4; i++) wr_reg(6'h11, 16'(i));
        repeat (4) pop(2'b01);
        @(negedge clk_sys);
        chk("addr_wrap", ch_addr[14:0], 0);
        for (int i = 0; i < 4; i++) wr_reg(6'h11, 16'(i));
        repeat (3) pop(2'b01);
        ri_en = 1; ri_wren = 1; ri_addr = 6'h10; from_cpu = 16'h1234; ch_pop = 2'b01;
        tick(); idle();
        @(negedge clk_sys);
        chk("addr_write_wins", ch_addr[14:0], 15'h1234);
        wr_reg(6'h11, 16'h5555);
        pop(2'b01);
        @(negedge clk_sys);
        chk("addr_cnt_cleared", ch_addr[14:0], 15'h1234);
        // reset mid-burst
        for (int i = 0; i < 5; i++) wr_reg(6'h11, 16'(16'h300 + i));
        pop(2'b01);
        ch_pop = 2'b01; tick(); idle();
        #2 rst = 1;
        @(negedge clk_sys);
        chk("mid_rst_empty", ch_empty, 2'b11);
        chk("mid_rst_addr", ch_addr, 0);
        chk("mid_rst_irq", irq, 0);
        tick(); tick();
        rst = 0;
        wr_reg(6'h11, 16'hBEEF);
        @(negedge clk_sys);
        chk("post_rst_head", ch_data[15:0], 16'hBEEF);
        pop(2'b01);
        @(negedge clk_sys);
        chk("post_rst_empty", ch_empty[0], 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            ri_en = $urandom_range(0, 9) < 8;
            ri_wren = $urandom_range(0, 9) < 6;
            ri_ren = 1'($urandom_range(0, 1));
            ri_addr = r < 3 ? 6'(r) : r < 5 ? 6'($urandom_range(3, 63)) :
                      r < 12 ? (r[0] ? 6'h11 : 6'h15) : 6'(16 + $urandom_range(0, 15));
            from_cpu = $urandom_range(0, 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            for (int c = 0; c < NCH; c++) ch_pop[c] = $urandom_range(0, 99) < (i < 1500 ? 5 : 35);
            tick();
        end
        idle();
        tick();
        @(negedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
